uart_rx_ctrl: RTL and testbench

Bit-timing and frame controller for the `uart_rx` receiver datapath. It watches the serial line and generates the mid-bit `en_b` strobes that step the receiver. It validates the start and stop bits, resets the receiver on bad frames, and hands completed bytes downstream over a valid/ready port. The block sits between the raw `rx` pin and the byte consumer. `uart_rx` is instantiated beside it with `en_b` and `rst` driven from this block.

---
 rtl/uart_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive bit-timing, frame check and byte holding register
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       baud_en,
  output logic       rx_rst,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  input  logic       clr,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_CHK, BITS, WAIT_HIGH} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     idx;
  // A good stop sample latches the byte here; the holding register takes it one cycle later.
  logic           cap_pend;
  logic [7:0]     cap_byte;

  // Frame FSM: baud timing, start/stop validation, receiver resets and frame error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 4'd0;
      baud_en   <= 1'b0;
      rx_rst    <= 1'b1;
      busy      <= 1'b0;
      cap_pend  <= 1'b0;
      cap_byte  <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      baud_en  <= 1'b0;
      rx_rst   <= 1'b0;
      cap_pend <= 1'b0;
      busy     <= (state != IDLE);
      if (clr) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= 4'd0;
          if (!rx) state <= START_CHK;
        end
        START_CHK: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx) begin
              baud_en <= 1'b1;
              idx     <= 4'd1;
              state   <= BITS;
            end else begin
              // Start bit vanished before mid-bit: treat as line noise.
              rx_rst <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BITS: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (idx == 4'd9) begin
              idx <= 4'd0;
              if (rx && rx_done) begin
                baud_en  <= 1'b1;
                cap_pend <= 1'b1;
                cap_byte <= rx_data;
                state    <= IDLE;
              end else begin
                rx_rst    <= 1'b1;
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              baud_en <= 1'b1;
              idx     <= idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A line stuck low (break) must not look like a new start bit.
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output holding register with overrun detection; a capture wins over a plain handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clr) overrun <= 1'b0;
      if (cap_pend) begin
        if (!m_valid || m_ready) begin
          m_data  <= cap_byte;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       baud_en;
  logic       rx_rst;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       clr;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int         b_cnt;
  int         b_bad;
  int         mv_at;
  int         rr_at;
  int         fe_at;
  logic [7:0] mv_data;

  uart_rx_ctrl #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .baud_en   (baud_en),
    .rx_rst    (rx_rst),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .clr       (clr),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural uart_rx: start, 8 data bits LSB first, then STOP until the next strobe.
  logic [3:0] bcnt;
  logic [7:0] shreg;
  always_ff @(posedge clk) begin
    if (rst || rx_rst) begin
      bcnt  <= 4'd0;
      shreg <= 8'h00;
    end else if (baud_en) begin
      if (bcnt >= 4'd1 && bcnt <= 4'd8) shreg <= {rx, shreg[7:1]};
      bcnt <= (bcnt == 4'd9) ? 4'd0 : bcnt + 4'd1;
    end
  end
  assign rx_done = (bcnt == 4'd9);
  assign rx_data = shreg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Drives one 160-cycle frame; cycle i is the edge t0+i. rdy_i >= 0 raises m_ready for that edge only.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rdy_i);
    logic [9:0] bits;
    logic       prev_mv;
    logic       prev_rr;
    logic       prev_fe;
    logic       saved_rdy;
    logic       exp_b;
    bits      = {stop_bit, data, 1'b0};
    b_cnt     = 0;
    b_bad     = 0;
    mv_at     = -1;
    rr_at     = -1;
    fe_at     = -1;
    mv_data   = 8'h00;
    prev_mv   = m_valid;
    prev_rr   = rx_rst;
    prev_fe   = frame_err;
    saved_rdy = m_ready;
    for (int i = 0; i < 160; i++) begin
      rx = bits[i / 16];
      if (i == rdy_i) m_ready = 1'b1;
      else if (rdy_i >= 0 && i == rdy_i + 1) m_ready = saved_rdy;
      step();
      exp_b = (i >= 8) && ((i - 8) % 16 == 0) && ((i < 152) || (i == 152 && stop_bit));
      if (baud_en) b_cnt++;
      if (baud_en !== exp_b) b_bad++;
      if (m_valid && !prev_mv && mv_at < 0) begin
        mv_at   = i;
        mv_data = m_data;
      end
      if (rx_rst && !prev_rr && rr_at < 0) rr_at = i;
      if (frame_err && !prev_fe && fe_at < 0) fe_at = i;
      prev_mv = m_valid;
      prev_rr = rx_rst;
      prev_fe = frame_err;
    end
    if (rdy_i >= 159) m_ready = saved_rdy;
  endtask

  initial begin
    int   cnt_a;
    int   cnt_b;
    int   idx_a;
    logic busy8;
    logic busy9;

    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b0;
    clr     = 1'b0;

    // Reset state
    step(); step(); step();
    check("rst_rx_rst", rx_rst, 1);
    check("rst_baud_en", baud_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("rst_release_rx_rst", rx_rst, 0);
    idle(4);

    // Good byte 0xA5
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1);
    check("good_baud_cnt", b_cnt, 10);
    check("good_baud_timing_errs", b_bad, 0);
    check("good_mv_at", mv_at, 153);
    check("good_m_data", mv_data, 8'hA5);
    check("good_rx_rst", rr_at, -1);
    check("good_frame_err", frame_err, 0);
    check("good_overrun", overrun, 0);
    check("good_accepted", m_valid, 0);
    idle(4);

    // Glitch: low for 3 cycles
    cnt_a = 0; cnt_b = 0; idx_a = -1; busy8 = 1'b0; busy9 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx = (i < 3) ? 1'b0 : 1'b1;
      step();
      if (baud_en) cnt_a++;
      if (rx_rst) begin
        cnt_b++;
        if (idx_a < 0) idx_a = i;
      end
      if (i == 8) busy8 = busy;
      if (i == 9) busy9 = busy;
    end
    check("glitch_baud_cnt", cnt_a, 0);
    check("glitch_rx_rst_cnt", cnt_b, 1);
    check("glitch_rx_rst_at", idx_a, 8);
    check("glitch_busy_at8", busy8, 1);
    check("glitch_busy_at9", busy9, 0);

    // Bad stop bit, then a break of 40 cycles
    send_frame(8'h3C, 1'b0, -1);
    check("bad_fe_at", fe_at, 152);
    check("bad_rr_at", rr_at, 152);
    check("bad_mv_at", mv_at, -1);
    check("bad_baud_cnt", b_cnt, 9);
    check("bad_baud_timing_errs", b_bad, 0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      rx = 1'b0;
      step();
      if (!busy) cnt_a++;
      if (baud_en) cnt_b++;
    end
    check("break_not_busy_cycles", cnt_a, 0);
    check("break_baud_cnt", cnt_b, 0);
    idle(2);
    check("break_end_busy", busy, 0);
    idle(3);
    send_frame(8'h55, 1'b1, -1);
    check("after_break_mv_at", mv_at, 153);
    check("after_break_data", mv_data, 8'h55);
    check("after_break_fe_sticky", frame_err, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_frame_err", frame_err, 0);
    idle(4);

    // Overrun with consumer stalled
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    check("ovr_first_data", mv_data, 8'h11);
    send_frame(8'h22, 1'b1, -1);
    check("ovr_m_data_kept", m_data, 8'h11);
    check("ovr_m_valid", m_valid, 1);
    check("ovr_flag", overrun, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovr_clr", overrun, 0);
    m_ready = 1'b1;
    step();
    check("ovr_drain", m_valid, 0);
    m_ready = 1'b0;
    idle(4);

    // Accept in the same cycle as a new capture
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 153);
    check("same_m_data", m_data, 8'h22);
    check("same_m_valid", m_valid, 1);
    check("same_overrun", overrun, 0);
    idle(4);

    // Reset in the middle of a frame
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin
      rx  = (i >= 70) ? 1'b1 : ((i < 16) ? 1'b0 : 1'b1 ^ (i[4]));
      rst = (i == 70 || i == 71);
      step();
      if (i == 70) begin
        check("mrst_rx_rst", rx_rst, 1);
        check("mrst_m_valid", m_valid, 0);
        check("mrst_m_data", m_data, 8'h00);
        check("mrst_busy", busy, 0);
        check("mrst_baud_en", baud_en, 0);
        check("mrst_flags", {frame_err, overrun}, 0);
      end
      if (i == 71) check("mrst_rx_rst_hold", rx_rst, 1);
      if (i == 72) check("mrst_rx_rst_drop", rx_rst, 0);
      if (i >= 72 && (baud_en || busy)) cnt_a++;
    end
    rst = 1'b0;
    check("mrst_quiet_after", cnt_a, 0);
    m_ready = 1'b1;
    send_frame(8'hF0, 1'b1, -1);
    check("mrst_next_mv_at", mv_at, 153);
    check("mrst_next_data", mv_data, 8'hF0);
    check("mrst_next_baud_cnt", b_cnt, 10);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
